// File: rtl/rs_encode_line_demux_out.sv
// -----------------------------------------------------------------------------
// rs_encode_line_demux_out
//
// Packs the RS encoder's codeword, one symbol per cycle, into DATA_W-wide lines
// for a line-oriented sink. Once the sink has taken the final line, a done pulse
// goes back to the input controller so that it can admit the next message.
// A codeword is only admitted after the input controller signals, with a done
// pulse, that it has finished feeding the message.
//
// Ports
//   clk                    clock
//   rst                    synchronous active-high reset
//   src_out_byte_val       symbol valid from the encoder FIFO
//   src_out_byte           codeword symbol, first-produced symbol first
//   out_src_byte_rdy       symbol accepted when val & rdy
//   out_dst_line_val       packed line valid
//   out_dst_line           packed line, first symbol in the MSB lane
//   out_dst_line_last      final line of the codeword
//   out_dst_line_padbytes  zero pad symbols at the low end of the line
//   dst_out_line_rdy       sink ready
//   in_ctrl_out_ctrl_done  pulse: input stage finished feeding a message
//   out_ctrl_in_ctrl_done  pulse: last line of the codeword taken by the sink
//
// Optional build macro RS_ENCODE_LINE_OUT_CNT_EN adds:
//   out_codeword_cnt       completed codewords (wraps)
//   out_stall_cnt          OUTPUT cycles with the sink not ready (saturates)
// -----------------------------------------------------------------------------
module rs_encode_line_demux_out #(
   parameter  int DATA_W          = 256,
   parameter  int RS_WORD_W       = 8,
   parameter  int RS_N            = 255,
   localparam int DATA_BYTES      = DATA_W / RS_WORD_W,
   localparam int NUM_OUT_LINES   = (RS_N + DATA_BYTES - 1) / DATA_BYTES,
   localparam int LAST_LINE_BYTES = RS_N - (NUM_OUT_LINES - 1) * DATA_BYTES,
   localparam int PAD_W           = $clog2(DATA_BYTES + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 src_out_byte_val,
   input  logic [RS_WORD_W-1:0] src_out_byte,
   output logic                 out_src_byte_rdy,
   output logic                 out_dst_line_val,
   output logic [DATA_W-1:0]    out_dst_line,
   output logic                 out_dst_line_last,
   output logic [PAD_W-1:0]     out_dst_line_padbytes,
   input  logic                 dst_out_line_rdy,
   input  logic                 in_ctrl_out_ctrl_done,
   output logic                 out_ctrl_in_ctrl_done
`ifdef RS_ENCODE_LINE_OUT_CNT_EN
   ,
   output logic [31:0]          out_codeword_cnt,
   output logic [31:0]          out_stall_cnt
`endif
);

   localparam int LANE_W   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam int LINE_W   = (NUM_OUT_LINES > 1) ? $clog2(NUM_OUT_LINES) : 1;
   localparam int SYM_W    = $clog2(RS_N + 1);
   localparam int LAST_PAD = DATA_BYTES - LAST_LINE_BYTES;

   typedef enum logic [1:0] {
      WAIT_START = 2'd0,
      ACCUM      = 2'd1,
      OUTPUT     = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                pending_q, pending_d;
   logic [LANE_W-1:0]   lane_cnt_q, lane_cnt_d;
   logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
   logic [SYM_W-1:0]    sym_cnt_q, sym_cnt_d;
   logic [DATA_W-1:0]   line_q, line_d;
   logic                done_q, done_d;

   logic                last_lane;
   logic                last_sym;
   logic                last_line;

   assign last_lane = (lane_cnt_q == LANE_W'(DATA_BYTES - 1));
   assign last_sym  = (sym_cnt_q  == SYM_W'(RS_N - 1));
   assign last_line = (line_cnt_q == LINE_W'(NUM_OUT_LINES - 1));

   always_comb begin
      state_d    = state_q;
      // A done pulse is remembered in any state; a repeat while set is absorbed.
      pending_d  = pending_q | in_ctrl_out_ctrl_done;
      lane_cnt_d = lane_cnt_q;
      line_cnt_d = line_cnt_q;
      sym_cnt_d  = sym_cnt_q;
      line_d     = line_q;
      done_d     = 1'b0;

      case (state_q)
         WAIT_START: begin
            if (pending_q) begin
               state_d   = ACCUM;
               pending_d = in_ctrl_out_ctrl_done;
            end
         end

         ACCUM: begin
            if (src_out_byte_val) begin
               // Constant lane selects: lane k sits at the k-th symbol from the MSB.
               for (int k = 0; k < DATA_BYTES; k++) begin
                  if (lane_cnt_q == LANE_W'(k)) begin
                     line_d[DATA_W-1-k*RS_WORD_W -: RS_WORD_W] = src_out_byte;
                  end
               end
               if (last_lane || last_sym) begin
                  // Lane count is held here and cleared when the line is taken.
                  state_d   = OUTPUT;
                  sym_cnt_d = last_sym ? '0 : sym_cnt_q + 1'b1;
               end else begin
                  lane_cnt_d = lane_cnt_q + 1'b1;
                  sym_cnt_d  = sym_cnt_q + 1'b1;
               end
            end
         end

         OUTPUT: begin
            if (dst_out_line_rdy) begin
               line_d     = '0;
               lane_cnt_d = '0;
               if (last_line) begin
                  state_d    = WAIT_START;
                  line_cnt_d = '0;
                  sym_cnt_d  = '0;
                  done_d     = 1'b1;
               end else begin
                  state_d    = ACCUM;
                  line_cnt_d = line_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = WAIT_START;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WAIT_START;
         pending_q  <= 1'b0;
         lane_cnt_q <= '0;
         line_cnt_q <= '0;
         sym_cnt_q  <= '0;
         line_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         lane_cnt_q <= lane_cnt_d;
         line_cnt_q <= line_cnt_d;
         sym_cnt_q  <= sym_cnt_d;
         line_q     <= line_d;
         done_q     <= done_d;
      end
   end

   // Handshake outputs decode from registered state only, so rdy never
   // depends combinationally on src_out_byte_val.
   assign out_src_byte_rdy      = (state_q == ACCUM);
   assign out_dst_line_val      = (state_q == OUTPUT);
   assign out_dst_line          = line_q;
   assign out_dst_line_last     = (state_q == OUTPUT) && last_line;
   assign out_dst_line_padbytes = ((state_q == OUTPUT) && last_line) ? PAD_W'(LAST_PAD) : '0;
   assign out_ctrl_in_ctrl_done = done_q;

`ifdef RS_ENCODE_LINE_OUT_CNT_EN
   logic [31:0] cw_cnt_q;
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cw_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (done_q) begin
            cw_cnt_q <= cw_cnt_q + 32'd1;
         end
         if ((state_q == OUTPUT) && !dst_out_line_rdy && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign out_codeword_cnt = cw_cnt_q;
   assign out_stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rs_encode_line_demux_out.sv
// -----------------------------------------------------------------------------
// Bench for rs_encode_line_demux_out. Instance A uses the default geometry
// (256-bit lines, 255-symbol codeword); instance B uses 64-bit lines and a
// 16-symbol codeword. Expected lines are built from the symbol stream when a
// codeword is queued and popped as the sink accepts lines.
// -----------------------------------------------------------------------------
module tb_rs_encode_line_demux_out;

   typedef struct {
      logic [255:0] data;
      logic         last;
      logic [7:0]   pad;
   } line_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Instance A signals
   logic         a_val = 1'b0;
   logic [7:0]   a_byte = 8'h00;
   logic         a_rdy;
   logic         a_lval;
   logic [255:0] a_line;
   logic         a_last;
   logic [5:0]   a_pad;
   logic         a_srdy = 1'b1;
   logic         a_dn = 1'b0;
   logic         a_done;

   // Instance B signals
   logic         b_val = 1'b0;
   logic [7:0]   b_byte = 8'h00;
   logic         b_rdy;
   logic         b_lval;
   logic [63:0]  b_line;
   logic         b_last;
   logic [3:0]   b_pad;
   logic         b_srdy = 1'b1;
   logic         b_dn = 1'b0;
   logic         b_done;

`ifdef RS_ENCODE_LINE_OUT_CNT_EN
   logic [31:0]  a_cw_cnt, a_st_cnt, b_cw_cnt, b_st_cnt;
`endif

   rs_encode_line_demux_out u_dut_a (
      .clk                   (clk),
      .rst                   (rst),
      .src_out_byte_val      (a_val),
      .src_out_byte          (a_byte),
      .out_src_byte_rdy      (a_rdy),
      .out_dst_line_val      (a_lval),
      .out_dst_line          (a_line),
      .out_dst_line_last     (a_last),
      .out_dst_line_padbytes (a_pad),
      .dst_out_line_rdy      (a_srdy),
      .in_ctrl_out_ctrl_done (a_dn),
      .out_ctrl_in_ctrl_done (a_done)
`ifdef RS_ENCODE_LINE_OUT_CNT_EN
      ,
      .out_codeword_cnt      (a_cw_cnt),
      .out_stall_cnt         (a_st_cnt)
`endif
   );

   rs_encode_line_demux_out #(.DATA_W(64), .RS_WORD_W(8), .RS_N(16)) u_dut_b (
      .clk                   (clk),
      .rst                   (rst),
      .src_out_byte_val      (b_val),
      .src_out_byte          (b_byte),
      .out_src_byte_rdy      (b_rdy),
      .out_dst_line_val      (b_lval),
      .out_dst_line          (b_line),
      .out_dst_line_last     (b_last),
      .out_dst_line_padbytes (b_pad),
      .dst_out_line_rdy      (b_srdy),
      .in_ctrl_out_ctrl_done (b_dn),
      .out_ctrl_in_ctrl_done (b_done)
`ifdef RS_ENCODE_LINE_OUT_CNT_EN
      ,
      .out_codeword_cnt      (b_cw_cnt),
      .out_stall_cnt         (b_st_cnt)
`endif
   );

   logic [7:0] src_a[$];
   logic [7:0] src_b[$];
   line_t      exp_a[$];
   line_t      exp_b[$];

   int n_assert = 0;
   int n_fail   = 0;
   int a_lidx = 0;
   int a_done_cnt = 0;
   int b_done_cnt = 0;
   int stall_line_a = -1;
   int stall_left_a = 0;
   bit b_auto = 1'b0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue a codeword of consecutive symbols starting at base; only nsrc
   // symbols are offered by the source, but all expected lines are built.
   task automatic push_cw(input bit b, input int base, input int nsrc);
      int dw, n, db, nl, llb, k;
      line_t ln;
      dw  = b ? 64 : 256;
      n   = b ? 16 : 255;
      db  = dw / 8;
      nl  = (n + db - 1) / db;
      llb = n - (nl - 1) * db;
      for (int i = 0; i < nsrc; i++) begin
         if (b) src_b.push_back(8'(base + i));
         else   src_a.push_back(8'(base + i));
      end
      for (int li = 0; li < nl; li++) begin
         ln.data = '0;
         for (int lane = 0; lane < db; lane++) begin
            k = li * db + lane;
            if (k < n) ln.data[dw-1-lane*8 -: 8] = 8'(base + k);
         end
         ln.last = (li == nl - 1);
         ln.pad  = ln.last ? 8'(db - llb) : 8'd0;
         if (b) exp_b.push_back(ln);
         else   exp_a.push_back(ln);
      end
   endtask

   // One clock: record handshakes that complete at this edge, check outputs
   // #1 after the edge, then drive inputs for the next edge.
   task automatic tick();
      bit sxa, lxa, lla, sxb, lxb, llb, rpre;
      rpre = rst;
      sxa = a_val && a_rdy;
      lxa = a_lval && a_srdy;
      lla = lxa && a_last;
      sxb = b_val && b_rdy;
      lxb = b_lval && b_srdy;
      llb = lxb && b_last;
      @(posedge clk);
      #1;
      if (sxa) src_a.delete(0);
      if (sxb) src_b.delete(0);
      if (lxa && exp_a.size() > 0) exp_a.delete(0);
      if (lxb && exp_b.size() > 0) exp_b.delete(0);
      if (lxa) a_lidx = lla ? 0 : a_lidx + 1;
      if (rpre) a_lidx = 0;

      chk("done_a", {255'd0, a_done}, {255'd0, lla && !rpre});
      chk("done_b", {255'd0, b_done}, {255'd0, llb && !rpre});
      if (a_done) a_done_cnt++;
      if (b_done) b_done_cnt++;

      if (a_lval) begin
         if (exp_a.size() == 0) begin
            chk("extra_line_a", {255'd0, a_lval}, 256'd0);
         end else begin
            chk("line_a", a_line, exp_a[0].data);
            chk("last_a", {255'd0, a_last}, {255'd0, exp_a[0].last});
            chk("pad_a", {250'd0, a_pad}, {248'd0, exp_a[0].pad});
            chk("rdy_in_output_a", {255'd0, a_rdy}, 256'd0);
         end
      end
      if (b_lval) begin
         if (exp_b.size() == 0) begin
            chk("extra_line_b", {255'd0, b_lval}, 256'd0);
         end else begin
            chk("line_b", {192'd0, b_line}, exp_b[0].data);
            chk("last_b", {255'd0, b_last}, {255'd0, exp_b[0].last});
            chk("pad_b", {252'd0, b_pad}, {248'd0, exp_b[0].pad});
         end
      end

      a_val  = (src_a.size() > 0);
      a_byte = a_val ? src_a[0] : 8'h00;
      b_val  = (src_b.size() > 0);
      b_byte = b_val ? src_b[0] : 8'h00;
      if (a_lval && (a_lidx == stall_line_a) && (stall_left_a > 0)) begin
         a_srdy = 1'b0;
         stall_left_a--;
      end else begin
         a_srdy = 1'b1;
      end
      b_srdy = 1'b1;
      // Done pulse coincident with the last-line accept, when more is queued.
      if (b_auto) b_dn = b_lval && b_last && (src_b.size() > 0);
   endtask

   task automatic drain(input int max_cyc);
      int i;
      i = 0;
      while ((exp_a.size() > 0 || exp_b.size() > 0) && i < max_cyc) begin
         tick();
         i++;
      end
      chk("drain_a", 256'(exp_a.size()), 256'd0);
      chk("drain_b", 256'(exp_b.size()), 256'd0);
   endtask

   task automatic check_reset();
      chk("rst_rdy_a",  {255'd0, a_rdy},  256'd0);
      chk("rst_lval_a", {255'd0, a_lval}, 256'd0);
      chk("rst_last_a", {255'd0, a_last}, 256'd0);
      chk("rst_pad_a",  {250'd0, a_pad},  256'd0);
      chk("rst_done_a", {255'd0, a_done}, 256'd0);
      chk("rst_line_a", a_line, 256'd0);
      chk("rst_rdy_b",  {255'd0, b_rdy},  256'd0);
      chk("rst_lval_b", {255'd0, b_lval}, 256'd0);
      chk("rst_done_b", {255'd0, b_done}, 256'd0);
   endtask

   initial begin
      int snap, i;

      // Reset
      rst = 1'b1;
      tick();
      tick();
      check_reset();
      rst = 1'b0;

      // Symbols offered before the done pulse must not be taken
      push_cw(1'b0, 0, 255);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("rdy_before_done", {255'd0, a_rdy}, 256'd0);
      end
      chk("src_val_held", {255'd0, a_val}, 256'd1);
      a_dn = 1'b1;
      tick();
      a_dn = 1'b0;
      chk("rdy_pending_cycle", {255'd0, a_rdy}, 256'd0);
      tick();
      chk("rdy_after_pending", {255'd0, a_rdy}, 256'd1);
      drain(2000);
      for (int c = 0; c < 3; c++) tick();
      chk("done_count_cw1", 256'(a_done_cnt), 256'd1);

      // Sink stalls line 3 for five cycles
      stall_line_a = 3;
      stall_left_a = 5;
      push_cw(1'b0, 8'h10, 255);
      a_dn = 1'b1;
      tick();
      a_dn = 1'b0;
      drain(2000);
      for (int c = 0; c < 3; c++) tick();
      chk("stall_consumed", 256'(stall_left_a), 256'd0);
      chk("done_count_cw2", 256'(a_done_cnt), 256'd2);
      stall_line_a = -1;
`ifdef RS_ENCODE_LINE_OUT_CNT_EN
      chk("codeword_cnt_a", {224'd0, a_cw_cnt}, 256'd2);
      chk("stall_cnt_a", {224'd0, a_st_cnt}, 256'd5);
`endif

      // Narrow instance: two back-to-back codewords
      b_auto = 1'b1;
      push_cw(1'b1, 8'hA0, 16);
      push_cw(1'b1, 8'hC0, 16);
      b_dn = 1'b1;
      tick();
      drain(500);
      for (int c = 0; c < 3; c++) tick();
      chk("done_count_b", 256'(b_done_cnt), 256'd2);
      b_auto = 1'b0;
      b_dn = 1'b0;
`ifdef RS_ENCODE_LINE_OUT_CNT_EN
      chk("codeword_cnt_b", {224'd0, b_cw_cnt}, 256'd2);
`endif

      // Reset after 40 symbols of a codeword
      snap = a_done_cnt;
      push_cw(1'b0, 8'h40, 40);
      a_dn = 1'b1;
      tick();
      a_dn = 1'b0;
      i = 0;
      while (src_a.size() > 0 && i < 500) begin
         tick();
         i++;
      end
      chk("src_drained_40", 256'(src_a.size()), 256'd0);
      for (int c = 0; c < 3; c++) tick();
      chk("lines_before_rst", 256'(exp_a.size()), 256'd7);
      rst = 1'b1;
      tick();
      check_reset();
      rst = 1'b0;
      exp_a.delete();
      src_a.delete();
      chk("no_done_from_rst", 256'(a_done_cnt), 256'(snap));
`ifdef RS_ENCODE_LINE_OUT_CNT_EN
      chk("codeword_cnt_rst", {224'd0, a_cw_cnt}, 256'd0);
`endif

      // Fresh codeword after reset
      push_cw(1'b0, 8'h80, 255);
      a_dn = 1'b1;
      tick();
      a_dn = 1'b0;
      drain(2000);
      for (int c = 0; c < 3; c++) tick();
      chk("done_count_after_rst", 256'(a_done_cnt), 256'(snap + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
